// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// controller state type and the alignment/legality check used at request
// acceptance.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WRITE,
        RESP
    } lsu_state_t;

    // 1 when the size code is legal and the byte offset is naturally aligned.
    function automatic logic lsu_access_ok(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (offset[0] == 1'b0);
            SZ_WORD: ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and dataMemory.
//   req_*  : request from execute (valid/ready handshake)
//   resp_* : one-cycle completion pulse back to execute
//   mem_*  : word-wide strobes to dataMemory and its registered read data
// Modports: slave = the load/store unit, master = its surroundings.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memRead;
    logic              mem_memWrite;
    logic              mem_writeEnable;
    logic [DATA_W-1:0] mem_readData;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_writeData, mem_memRead, mem_memWrite, mem_writeEnable,
        input  mem_readData
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_writeData, mem_memRead, mem_memWrite, mem_writeEnable,
        output mem_readData
    );

endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic for sub-word accesses (little-endian).
//   size, offset : access size code and byte offset within the word
//   is_signed    : sign-extend the extracted load field
//   old_word     : word as currently held in memory
//   wdata        : store data (byte/half taken from the low bits)
//   merged_word  : old_word with only the addressed lane(s) replaced
//   load_result  : addressed field, extended to 32 bits
module load_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged_word,
    output logic [31:0] load_result
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_f;
    logic [15:0] half_f;

    always_comb begin
        byte_sh = {offset, 3'b000};
        half_sh = {offset[1], 4'b0000};
        byte_f  = 8'(old_word >> byte_sh);
        half_f  = 16'(old_word >> half_sh);

        merged_word = wdata;
        load_result = old_word;

        case (size)
            SZ_BYTE: begin
                merged_word = (old_word & ~(32'h0000_00FF << byte_sh))
                            | ({24'h0, wdata[7:0]} << byte_sh);
                load_result = {{24{is_signed & byte_f[7]}}, byte_f};
            end
            SZ_HALF: begin
                merged_word = (old_word & ~(32'h0000_FFFF << half_sh))
                            | ({16'h0, wdata[15:0]} << half_sh);
                load_result = {{16{is_signed & half_f[15]}}, half_f};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for dataMemory. Accepts one request at
// a time, converts the byte address to a word index, performs sub-word stores
// as read-modify-write and extracts/extends sub-word loads.
//   Clk : rising-edge clock
//   Rst : synchronous active-low reset (aborts any operation in flight)
//   bus : load_store_unit_if.slave - request, response and dataMemory signals
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic             Clk,
    input  logic             Rst,
    load_store_unit_if.slave bus
);

    lsu_state_t state, state_nxt;

    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_offset;
    logic [DATA_W-1:0] r_wdata;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] load_result;

    // mem_readData is the registered read issued in RD_ISSUE, so it is valid
    // throughout RD_CAPTURE and can feed the lane logic directly.
    load_store_align u_align (
        .size        (r_size),
        .offset      (r_offset),
        .is_signed   (r_signed),
        .old_word    (bus.mem_readData),
        .wdata       (r_wdata),
        .merged_word (merged_word),
        .load_result (load_result)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= IDLE;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write      <= bus.req_write;
                        r_size       <= bus.req_size;
                        r_signed     <= bus.req_signed;
                        r_offset     <= bus.req_addr[1:0];
                        r_wdata      <= bus.req_wdata;
                        mem_addr_q   <= {2'b00, bus.req_addr[ADDR_W-1:2]};
                        // Word stores write this directly; sub-word stores
                        // overwrite it with the merged word before WRITE.
                        mem_wdata_q  <= bus.req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= ~lsu_access_ok(bus.req_size, bus.req_addr[1:0]);
                    end
                end
                RD_CAPTURE: begin
                    if (r_write) begin
                        mem_wdata_q <= merged_word;
                    end else begin
                        resp_rdata_q <= load_result;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!lsu_access_ok(bus.req_size, bus.req_addr[1:0])) begin
                        state_nxt = RESP;
                    end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE:   state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = r_write ? WRITE : RESP;
            WRITE:      state_nxt = RESP;
            RESP:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Strobes decode from state alone; no path from req_* to mem_*.
    assign bus.req_ready       = (state == IDLE) && Rst;
    assign bus.resp_valid      = (state == RESP);
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_writeData   = mem_wdata_q;
    assign bus.mem_memRead     = (state == RD_ISSUE) || (state == RD_CAPTURE);
    assign bus.mem_memWrite    = (state == WRITE);
    assign bus.mem_writeEnable = (state == WRITE);

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end that sits directly upstream of `dataMemory` in the unpipelined datapath. It accepts one load or store request at a time from the execute stage. It converts the byte address to a word index and drives `dataMemory`'s word-wide strobes. Sub-word stores are performed as read-modify-write; sub-word loads are extracted and sign- or zero-extended.

## Interface

Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, word width; fixed at 32 and not otherwise supported.

Ports, clock and reset first:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready` at a rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend sub-word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the value is taken from the low bytes.
- `resp_valid`  out  1  one-cycle completion pulse; no back-pressure.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal size; valid with `resp_valid`.
- `mem_addr`  out  32  word index = `req_addr >> 2`, to `dataMemory.addr`.
- `mem_writeData`  out  32  to `dataMemory.writeData`.
- `mem_memRead`  out  1  to `dataMemory.memRead`.
- `mem_memWrite`  out  1  to `dataMemory.memWrite`.
- `mem_writeEnable`  out  1  to `dataMemory.writeEnable`.
- `mem_readData`  in  32  from `dataMemory.readData`.

## Operation

`dataMemory` behaviour this block relies on:
- It registers `readData` at a rising edge when `memRead` = 1.
- It writes `writeData` at a rising edge when `memWrite & writeEnable` = 1.

States are IDLE, RD_ISSUE, RD_CAPTURE, WRITE and RESP.

Transitions on an accepted request:
- Misaligned or illegal request → RESP with `err` set. No memory strobes are driven.
- Word store → WRITE.
- Any load, or a byte/half store → RD_ISSUE.

Per-state behaviour:
- RD_ISSUE: `mem_memRead`=1 → RD_CAPTURE.
- RD_CAPTURE: `mem_memRead`=1 and `mem_readData` is latched.
  - Load → RESP, with the extracted, extended result.
  - Store → WRITE, with merged data.
- WRITE: `mem_memWrite`=`mem_writeEnable`=1 → RESP.
- RESP: `resp_valid`=1 → IDLE, unconditionally.

Alignment:
- Half-word requires `addr[0]`=0.
- Word requires `addr[1:0]`=0.
- `req_size` 11 is always an error.

Lane and merge rules:
- Little-endian. Byte lane = `addr[1:0]`; half lane = `addr[1]`.
- Merge replaces only the target lane(s) with `req_wdata[7:0]` or `req_wdata[15:0]`.
- Extension: signed replicates the top bit of the extracted field; unsigned zero-fills.

Request handling:
- Request fields are registered at acceptance.
- Inputs are ignored outside IDLE.

## Timing

- Cycle 0 is the acceptance cycle; cycle N follows the N-th edge after acceptance.
- `resp_valid` latency:
  - Error: cycle 1.
  - Word store: cycle 2 (write strobe in cycle 1).
  - Load: cycle 3.
  - Sub-word store: cycle 4 (write strobe in cycle 3).
- `req_ready` returns in cycle after RESP. Back-to-back throughput is one request per latency+1 cycles.
- `mem_addr` and `mem_writeData` hold stable for every cycle in which a strobe is high.
- Reset values, with `Rst`=0 sampled:
  - State = IDLE.
  - `req_ready`=0 while `Rst`=0, then 1 after release.
  - `resp_valid`, `resp_err`, all `mem_*` strobes = 0.
  - `resp_rdata`, `mem_addr`, `mem_writeData` = 0.
- Reset mid-operation aborts the operation. No write strobe appears after the reset edge and no response is issued, so a sub-word store aborted before WRITE leaves memory unchanged.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `mem_*`.

## Structure

- Package `lsu_pkg` holds:
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - State enum `lsu_state_t`.
  - Alignment-check function.
- Combinational sub-module `load_store_align` holds:
  - Inputs: `size`, `offset[1:0]`, `signed`, `old_word`, `wdata`.
  - Outputs: `merged_word`, `load_result`.
  - It is instantiated once and unit-testable in isolation.
- The top level holds the FSM and registers only.

## Test plan

All scenarios run against a behavioural `dataMemory` model.

1. **Reset.** Hold `Rst`=0 for 2 cycles → all outputs 0 and `req_ready`=0. After release → `req_ready`=1 and no strobes.
2. **Word store and load.**
   - Store of 0xDEADBEEF to 0x10 → single cycle-1 strobe with `mem_addr`=4 and `mem_writeData`=0xDEADBEEF; `resp_valid` in cycle 2.
   - Load word from 0x10 → `resp_rdata`=0xDEADBEEF in cycle 3.
3. **Byte store and loads.**
   - Byte store of 0xAB to 0x11 over 0xDEADBEEF → written 0xDEADABEF in cycle 3.
   - Signed byte load from 0x11 → 0xFFFFFFAB.
   - Unsigned byte load from 0x11 → 0x000000AB.
4. **Half-word loads.** From 0x12 over 0xDEADABEF:
   - Signed → 0xFFFFDEAD.
   - Unsigned → 0x0000DEAD.
5. **Error responses.**
   - Word load at 0x13 → `resp_err`=1 and `resp_rdata`=0 in cycle 1, with no `mem_memRead`.
   - Half store at 0x11 → likewise, with no write.
6. **Reset abort.** Byte store of 0x55 to 0x10; assert `Rst`=0 during RD_CAPTURE → no `mem_memWrite` observed, word stays 0xDEADABEF, and no `resp_valid`.
